// File: rtl/fifo_cascade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_cascade_pkg
// Description : Shared defaults and width helpers for the fifo_cascade_n FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_cascade_pkg;

    localparam int C_WIDTH  = 36;
    localparam int C_DEPTH  = 512;
    localparam int C_STAGES = 2;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Room for every segment, every link word and the two prefetch slots.
    function automatic int dcount_w(input int stages, input int depth);
        return $clog2(stages * depth + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_seg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_seg
// Description : One registered-memory synchronous FIFO segment; a pop at
//               cycle t presents its word on dout at cycle t+1.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_seg
    import fifo_cascade_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int DEPTH = C_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    empty,
    output logic                    full
);

    localparam int c_pw = ptr_w(DEPTH);
    localparam int c_cw = cnt_w(DEPTH);
    localparam logic [c_pw-1:0] c_ptr_one = 1;
    localparam logic [c_cw-1:0] c_cnt_one = 1;
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_dout   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    assign dout  = r_dout;
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/fifo_cascade_n.sv
`default_nettype none
// ============================================================================
// Module      : fifo_cascade_n
// Description : STAGES chained fifo_seg segments with conservative transfer
//               links. Define FIFO_CASCADE_FWFT_EN for first-word-fall-through
//               output through a 2-entry prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_cascade_n
    import fifo_cascade_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH,
    parameter int DEPTH     = C_DEPTH,
    parameter int STAGES    = C_STAGES,
    parameter int AF_THRESH = STAGES * DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               wr_en,
    input  logic                               rd_en,
    output logic [WIDTH-1:0]                   dout,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [dcount_w(STAGES, DEPTH)-1:0] data_count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int c_cw  = cnt_w(DEPTH);
    localparam int c_cw1 = c_cw + 1;
    localparam int c_dw  = dcount_w(STAGES, DEPTH);

    logic [WIDTH-1:0]  w_seg_din   [STAGES];
    logic [WIDTH-1:0]  w_seg_dout  [STAGES];
    logic [c_cw-1:0]   w_seg_count [STAGES];
    logic [STAGES-1:0] w_seg_push;
    logic [STAGES-1:0] w_seg_pop;
    logic [STAGES-1:0] w_seg_empty;
    logic [STAGES-1:0] w_seg_full;
    // Bit k fires link k->k+1; the top bit feeds the prefetch buffer.
    logic [STAGES-1:0] w_link_fire;
    logic [STAGES-1:0] r_inflight;
    logic [1:0]        w_pf_occ;
    logic              r_overflow;
    logic              r_underflow;
    logic [c_dw-1:0]   w_sum;

    assign full          = w_seg_full[0];
    assign w_seg_push[0] = wr_en && !w_seg_full[0];
    assign w_seg_din[0]  = din;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        fifo_seg #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (w_seg_push[k]),
            .pop   (w_seg_pop[k]),
            .din   (w_seg_din[k]),
            .dout  (w_seg_dout[k]),
            .count (w_seg_count[k]),
            .empty (w_seg_empty[k]),
            .full  (w_seg_full[k])
        );
    end

    // Counting the in-flight word against the downstream room means a link
    // can never push into a full segment.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_link
        assign w_link_fire[k] = !w_seg_empty[k] && !w_seg_full[k+1] &&
                                ((c_cw1'(w_seg_count[k+1]) + c_cw1'(r_inflight[k])) < c_cw1'(DEPTH));
        assign w_seg_pop[k]    = w_link_fire[k];
        assign w_seg_push[k+1] = r_inflight[k];
        assign w_seg_din[k+1]  = w_seg_dout[k];
    end

`ifdef FIFO_CASCADE_FWFT_EN
    logic [WIDTH-1:0] r_pf_mem [2];
    logic             r_pf_wr;
    logic             r_pf_rd;
    logic [1:0]       r_pf_count;
    logic [1:0]       w_pf_next;
    logic             w_pf_valid;
    logic             w_rd_ok;
    logic             w_from_buf;
    logic             w_store;

    // The word arriving from the last segment is visible straight away, so
    // it counts as the head whenever the buffer itself is empty.
    assign w_pf_valid = (r_pf_count != 2'd0) || r_inflight[STAGES-1];
    assign w_rd_ok    = rd_en && w_pf_valid;
    assign w_from_buf = w_rd_ok && (r_pf_count != 2'd0);
    assign w_store    = r_inflight[STAGES-1] && !(w_rd_ok && (r_pf_count == 2'd0));
    assign w_pf_next  = r_pf_count + {1'b0, w_store} - {1'b0, w_from_buf};

    assign w_link_fire[STAGES-1] = !w_seg_empty[STAGES-1] && (w_pf_next < 2'd2);
    assign w_seg_pop[STAGES-1]   = w_link_fire[STAGES-1];
    assign empty    = !w_pf_valid;
    assign dout     = (r_pf_count != 2'd0) ? r_pf_mem[r_pf_rd] : w_seg_dout[STAGES-1];
    assign w_pf_occ = r_pf_count;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_pf_mem[r_pf_wr] <= w_seg_dout[STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_wr    <= 1'b0;
            r_pf_rd    <= 1'b0;
            r_pf_count <= 2'd0;
        end else begin
            r_pf_count <= w_pf_next;
            if (w_store) begin
                r_pf_wr <= ~r_pf_wr;
            end
            if (w_from_buf) begin
                r_pf_rd <= ~r_pf_rd;
            end
        end
    end
`else
    assign w_link_fire[STAGES-1] = 1'b0;
    assign w_seg_pop[STAGES-1]   = rd_en && !w_seg_empty[STAGES-1];
    assign empty    = w_seg_empty[STAGES-1];
    assign dout     = w_seg_dout[STAGES-1];
    assign w_pf_occ = 2'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_inflight  <= w_link_fire;
            r_overflow  <= r_overflow  | (wr_en && full);
            r_underflow <= r_underflow | (rd_en && empty);
        end
    end

    always_comb begin
        w_sum = c_dw'(w_pf_occ);
        for (int k = 0; k < STAGES; k++) begin
            w_sum = w_sum + c_dw'(w_seg_count[k]) + c_dw'(r_inflight[k]);
        end
    end

    assign data_count   = w_sum;
    assign almost_full  = (w_sum >= c_dw'(AF_THRESH));
    assign almost_empty = (w_sum <= c_dw'(AE_THRESH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_cascade_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_cascade_n
// Description : Randomised self-checking bench for fifo_cascade_n against a
//               queue model; honours FIFO_CASCADE_FWFT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_cascade_n;

    localparam int W  = 36;
    localparam int D  = 512;
    localparam int S  = 2;
    localparam int AF = S * D - 4;
    localparam int AE = 4;
    localparam int CW = $clog2(S * D + 3);
`ifdef FIFO_CASCADE_FWFT_EN
    localparam int CAP = S * D + 2;
    localparam int LAT = 2 * S;
`else
    localparam int CAP = S * D;
    localparam int LAT = 2 * S - 1;
`endif

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  din;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] data_count;
    logic          overflow;
    logic          underflow;

    fifo_cascade_n #(
        .WIDTH     (W),
        .DEPTH     (D),
        .STAGES    (S),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout;
    logic         exp_ovf;
    logic         exp_udf;
    int           n_vec;
    int           n_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_checks();
        check_val("rst_dout", dout, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_almost_empty", almost_empty, 1);
        check_val("rst_almost_full", almost_full, 0);
        check_val("rst_data_count", data_count, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_underflow", underflow, 0);
    endtask

    // One clock: drive at negedge, settle handshakes just before the rising
    // edge, then compare everything against the queue model after it.
    task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
        logic wacc;
        logic racc;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        #4;
        wacc = wr && !full;
        racc = rd && !empty;
        if (wr && full)  exp_ovf = 1'b1;
        if (rd && empty) exp_udf = 1'b1;
`ifdef FIFO_CASCADE_FWFT_EN
        if (!empty) begin
            if (q.size() == 0) check_val("data_without_write", empty, 1);
            else               check_val("fwft_head", dout, q[0]);
        end
        if (racc && q.size() != 0) void'(q.pop_front());
`else
        if (racc) begin
            if (q.size() == 0) check_val("read_without_write", empty, 1);
            else               exp_dout = q.pop_front();
        end
`endif
        if (wacc) q.push_back(d);
        @(posedge clk);
        #1;
        check_val("data_count", data_count, q.size());
        check_val("almost_full", almost_full, q.size() >= AF);
        check_val("almost_empty", almost_empty, q.size() <= AE);
        check_val("overflow", overflow, exp_ovf);
        check_val("underflow", underflow, exp_udf);
`ifndef FIFO_CASCADE_FWFT_EN
        check_val("dout", dout, exp_dout);
`endif
        if (q.size() == CAP) check_val("full_at_capacity", full, 1);
        if (full)  check_val("full_too_early", q.size() >= D, 1);
        if (empty) check_val("empty_with_backlog", q.size() <= 2 * S + 2, 1);
    endtask

    task automatic drain(input int budget);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < budget) begin
            step(1'b0, 1'b1, '0);
            guard++;
        end
        if (q.size() != 0) check_val("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [63:0] r64;
        int          wp;
        int          rp;
        n_vec    = 0;
        n_err    = 0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);

        // Single word latency through an empty cascade.
        step(1'b1, 1'b0, W'(36'hA5));
        for (int i = 1; i <= LAT; i++) begin
            check_val("latency_empty", empty, i < LAT);
            if (i < LAT) step(1'b0, 1'b0, '0);
        end
`ifdef FIFO_CASCADE_FWFT_EN
        check_val("a5_dout", dout, 36'hA5);
        step(1'b0, 1'b1, '0);
`else
        step(1'b0, 1'b1, '0);
        check_val("a5_dout", dout, 36'hA5);
`endif
        check_val("a5_drained", data_count, 0);

        // Read while empty: sticky underflow, nothing else moves.
        step(1'b0, 1'b1, '0);
        check_val("underflow_set", underflow, 1);

        // Fill to capacity, overflow one more, drain in order.
        for (int i = 0; i < CAP; i++) step(1'b1, 1'b0, W'(i));
        repeat (8) step(1'b0, 1'b0, '0);
        check_val("fill_full", full, 1);
        check_val("fill_count", data_count, CAP);
        step(1'b1, 1'b0, W'(36'hDEAD));
        check_val("overflow_set", overflow, 1);
        drain(CAP * 3);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 700; i++) begin
            r64 = {$urandom(), $urandom()};
            step(1'b1, 1'b0, r64[W-1:0]);
        end
        repeat (4) step(1'b0, 1'b0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, W'(36'h3C));
        drain(50);

        // Randomised traffic with varying write/read pressure.
        for (int ph = 0; ph < 6; ph++) begin
            wp = $urandom_range(20, 95);
            rp = $urandom_range(20, 95);
            for (int i = 0; i < 500; i++) begin
                r64 = {$urandom(), $urandom()};
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, r64[W-1:0]);
            end
        end
        drain(CAP * 3);

        // Sustained simultaneous read and write: no bubbles once primed.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, W'(i));
        repeat (10) step(1'b0, 1'b0, '0);
        for (int i = 0; i < 5000; i++) begin
            r64 = {$urandom(), $urandom()};
            step(1'b1, 1'b1, r64[W-1:0]);
            check_val("stream_bubble", empty, 0);
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
